// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand register with EX/MEM forwarding,
// load-use hazard detection and a saturating stall counter.
module operand_fetch #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [WORD_W-1:0] id_imm,
  output logic              id_ready,
  output logic [4:0]        rsel1,
  output logic [4:0]        rsel2,
  input  logic [WORD_W-1:0] rdat1,
  input  logic [WORD_W-1:0] rdat2,
  input  logic [WORD_W-1:0] ex_result,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_rd,
  input  logic [WORD_W-1:0] mem_wdat,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [4:0]        ex_rd,
  output logic [WORD_W-1:0] ex_opA,
  output logic [WORD_W-1:0] ex_opB,
  output logic [WORD_W-1:0] ex_rtdat,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Output register
  logic              r_ex_valid;
  logic              r_ex_regwrite;
  logic              r_ex_memread;
  logic [REG_W-1:0]  r_ex_rd;
  logic [WORD_W-1:0] r_ex_opA;
  logic [WORD_W-1:0] r_ex_opB;
  logic [WORD_W-1:0] r_ex_rtdat;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Combinational control and datapath
  logic              w_ex_can_fwd;
  logic              w_ex_hit_rs;
  logic              w_ex_hit_rt;
  logic              w_mem_hit_rs;
  logic              w_mem_hit_rt;
  logic [WORD_W-1:0] w_fwd_rs;
  logic [WORD_W-1:0] w_fwd_rt;
  logic [WORD_W-1:0] w_opB;
  logic              w_load_hit;
  logic              w_hazard;
  logic              w_advance;
  logic              w_load;
  logic              w_stall_inc;

  // Register-file read selects follow decode directly
  assign rsel1 = id_rs;
  assign rsel2 = id_rt;

  // EX-stage result is only forwardable for a valid, non-load register writer
  assign w_ex_can_fwd = r_ex_valid & r_ex_regwrite & ~r_ex_memread;

  // Source match detection; register 0 is never forwarded
  always_comb begin
    w_ex_hit_rs  = w_ex_can_fwd && (r_ex_rd == id_rs) && (id_rs != REG_ZERO);
    w_ex_hit_rt  = w_ex_can_fwd && (r_ex_rd == id_rt) && (id_rt != REG_ZERO);
    w_mem_hit_rs = mem_regwrite && (mem_rd == id_rs) && (id_rs != REG_ZERO);
    w_mem_hit_rt = mem_regwrite && (mem_rd == id_rt) && (id_rt != REG_ZERO);
  end

  // Forwarding mux for source 1: EX beats MEM beats register file
  always_comb begin
    w_fwd_rs = rdat1;
    if (w_ex_hit_rs) begin
      w_fwd_rs = ex_result;
    end else if (w_mem_hit_rs) begin
      w_fwd_rs = mem_wdat;
    end
  end

  // Forwarding mux for source 2: EX beats MEM beats register file
  always_comb begin
    w_fwd_rt = rdat2;
    if (w_ex_hit_rt) begin
      w_fwd_rt = ex_result;
    end else if (w_mem_hit_rt) begin
      w_fwd_rt = mem_wdat;
    end
  end

  // Operand B selects between immediate and forwarded rt
  assign w_opB = id_alusrc ? id_imm : w_fwd_rt;

  // Load-use hazard: a load in EX whose destination decode needs now
  always_comb begin
    w_load_hit = (r_ex_rd == id_rs) || (id_uses_rt && (r_ex_rd == id_rt));
    w_hazard   = id_valid && r_ex_valid && r_ex_memread &&
                 (r_ex_rd != REG_ZERO) && w_load_hit;
  end

  // Handshake: the output register can take a new entry when empty or draining
  assign w_advance   = ~r_ex_valid | ex_ready;
  assign w_load      = w_advance & id_valid & ~w_hazard;
  assign id_ready    = ~w_hazard & w_advance;
  assign w_stall_inc = w_hazard & ~flush;

  // Output register: flush squashes, advance loads or bubbles, otherwise hold
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_opA      <= '0;
      r_ex_opB      <= '0;
      r_ex_rtdat    <= '0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_load) begin
        r_ex_valid    <= 1'b1;
        r_ex_regwrite <= id_regwrite;
        r_ex_memread  <= id_memread;
        r_ex_rd       <= id_rd;
        r_ex_opA      <= w_fwd_rs;
        r_ex_opB      <= w_opB;
        r_ex_rtdat    <= w_fwd_rt;
      end else begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_regwrite = r_ex_regwrite;
  assign ex_memread  = r_ex_memread;
  assign ex_rd       = r_ex_rd;
  assign ex_opA      = r_ex_opA;
  assign ex_opB      = r_ex_opB;
  assign ex_rtdat    = r_ex_rtdat;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the operand-fetch stage.
module tb_operand_fetch;

  localparam int unsigned W = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_uses_rt, id_alusrc, id_regwrite, id_memread;
  logic [W-1:0]  id_imm;
  logic          id_ready;
  logic [4:0]    rsel1, rsel2;
  logic [W-1:0]  rdat1, rdat2;
  logic [W-1:0]  ex_result;
  logic          mem_regwrite;
  logic [4:0]    mem_rd;
  logic [W-1:0]  mem_wdat;
  logic          ex_ready, flush;
  logic          ex_valid, ex_regwrite, ex_memread;
  logic [4:0]    ex_rd;
  logic [W-1:0]  ex_opA, ex_opB, ex_rtdat;
  logic [15:0]   stall_cnt;

  logic [W-1:0]  rf [32];

  int n_total = 0;
  int n_bad   = 0;

  // Register file model: combinational read of the DUT's selects
  assign rdat1 = rf[rsel1];
  assign rdat2 = rf[rsel2];

  always #5 CLK = ~CLK;

  operand_fetch #(.WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_imm(id_imm), .id_ready(id_ready),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .ex_result(ex_result), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_wdat(mem_wdat), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rtdat(ex_rtdat),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_valid, m_regwrite, m_memread;
  logic [4:0]   m_rd;
  logic [W-1:0] m_opA, m_opB, m_rtdat;
  int unsigned  m_stall;

  // Value an instruction in decode sees for a source register
  function automatic logic [W-1:0] m_src(input logic [4:0] src);
    if (src == 5'd0) return rf[0];
    if (m_valid && m_regwrite && !m_memread && m_rd == src) return ex_result;
    if (mem_regwrite && mem_rd == src) return mem_wdat;
    return rf[src];
  endfunction

  function automatic logic m_hazard();
    return id_valid && m_valid && m_memread && (m_rd != 5'd0) &&
           ((m_rd == id_rs) || (id_uses_rt && (m_rd == id_rt)));
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_valid <= 1'b0; m_regwrite <= 1'b0; m_memread <= 1'b0; m_rd <= '0;
      m_opA <= '0; m_opB <= '0; m_rtdat <= '0; m_stall <= 0;
    end else begin
      if (m_hazard() && !flush && m_stall < 32'hFFFF) m_stall <= m_stall + 1;
      if (flush) m_valid <= 1'b0;
      else if (!m_valid || ex_ready) begin
        if (id_valid && !m_hazard()) begin
          m_valid    <= 1'b1;
          m_regwrite <= id_regwrite;
          m_memread  <= id_memread;
          m_rd       <= id_rd;
          m_opA      <= m_src(id_rs);
          m_rtdat    <= m_src(id_rt);
          m_opB      <= id_alusrc ? id_imm : m_src(id_rt);
        end else m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge CLK) begin
    chk("rsel1", 64'(rsel1), 64'(id_rs));
    chk("rsel2", 64'(rsel2), 64'(id_rt));
    chk("id_ready", 64'(id_ready), 64'(!m_hazard() && (!m_valid || ex_ready)));
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (m_valid) begin
      chk("ex_regwrite", 64'(ex_regwrite), 64'(m_regwrite));
      chk("ex_memread", 64'(ex_memread), 64'(m_memread));
      chk("ex_rd", 64'(ex_rd), 64'(m_rd));
      chk("ex_opA", 64'(ex_opA), 64'(m_opA));
      chk("ex_opB", 64'(ex_opB), 64'(m_opB));
      chk("ex_rtdat", 64'(ex_rtdat), 64'(m_rtdat));
    end else begin
      chk("no_x", 64'($isunknown({ex_regwrite, ex_memread, ex_rd, ex_opA, ex_opB, ex_rtdat})), 64'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rt = 0; id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_imm = 0;
    ex_result = 0; mem_regwrite = 0; mem_rd = 0; mem_wdat = 0;
    ex_ready = 1; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic ur, input logic asrc, input logic rw, input logic mr,
                       input logic [W-1:0] imm);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = ur; id_alusrc = asrc; id_regwrite = rw; id_memread = mr; id_imm = imm;
  endtask

  initial begin
    nRST = 0;
    set_idle();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;
    repeat (2) step();
    chk("rst_ex_valid", 64'(ex_valid), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    chk("rst_opA", 64'(ex_opA), 64'(0));
    chk("rst_rd", 64'(ex_rd), 64'(0));
    nRST = 1;

    // plain load with immediate
    rf[3] = 32'h11;
    issue(3, 0, 1, 0, 1, 1, 0, 32'h4);
    step();
    chk("plain_valid", 64'(ex_valid), 64'(1));
    chk("plain_opA", 64'(ex_opA), 64'(32'h11));
    chk("plain_opB", 64'(ex_opB), 64'(32'h4));

    // EX forward beats MEM forward
    issue(1, 2, 5, 1, 0, 1, 0, 0);
    step();
    ex_result = 32'hAA; mem_regwrite = 1; mem_rd = 5; mem_wdat = 32'hBB;
    issue(5, 0, 6, 0, 1, 1, 0, 32'h8);
    step();
    chk("exfwd_opA", 64'(ex_opA), 64'(32'hAA));
    mem_regwrite = 0;

    // load-use: one bubble then MEM supplies the loaded value
    rf[7] = 32'h99;
    issue(1, 2, 7, 1, 0, 1, 1, 0);
    step();
    issue(2, 7, 8, 1, 0, 1, 0, 0);
    #1;
    chk("lu_id_ready", 64'(id_ready), 64'(0));
    step();
    chk("lu_bubble", 64'(ex_valid), 64'(0));
    chk("lu_stall", 64'(stall_cnt), 64'(1));
    mem_regwrite = 1; mem_rd = 7; mem_wdat = 32'h55;
    step();
    chk("lu_valid", 64'(ex_valid), 64'(1));
    chk("lu_rtdat", 64'(ex_rtdat), 64'(32'h55));
    chk("lu_opB", 64'(ex_opB), 64'(32'h55));
    mem_regwrite = 0;

    // register 0 is never forwarded and never causes a hazard
    issue(1, 2, 0, 1, 0, 1, 0, 0);
    step();
    ex_result = 32'hFF;
    issue(0, 0, 9, 0, 1, 1, 0, 32'h1);
    step();
    chk("r0_opA", 64'(ex_opA), 64'(0));
    issue(1, 2, 0, 1, 0, 1, 1, 0);
    step();
    issue(0, 0, 9, 1, 0, 1, 0, 0);
    #1;
    chk("r0_no_hazard", 64'(id_ready), 64'(1));
    step();
    chk("r0_valid", 64'(ex_valid), 64'(1));
    chk("r0_stall", 64'(stall_cnt), 64'(1));

    // backpressure hold, then flush together with a hazard
    rf[2] = 32'h22; rf[3] = 32'h11;
    issue(2, 3, 4, 1, 0, 1, 1, 0);
    step();
    chk("bp_load_opA", 64'(ex_opA), 64'(32'h22));
    ex_ready = 0;
    issue(4, 0, 10, 0, 1, 1, 0, 0);
    mem_regwrite = 1; mem_rd = 2; mem_wdat = 32'h77;
    for (int k = 0; k < 3; k++) begin
      rf[2] = $urandom; rf[3] = $urandom;
      step();
      chk("bp_valid", 64'(ex_valid), 64'(1));
      chk("bp_opA", 64'(ex_opA), 64'(32'h22));
      chk("bp_opB", 64'(ex_opB), 64'(32'h11));
      chk("bp_rtdat", 64'(ex_rtdat), 64'(32'h11));
      chk("bp_rd", 64'(ex_rd), 64'(4));
      chk("bp_id_ready", 64'(id_ready), 64'(0));
    end
    chk("bp_stall", 64'(stall_cnt), 64'(4));
    flush = 1;
    step();
    chk("flush_valid", 64'(ex_valid), 64'(0));
    chk("flush_stall", 64'(stall_cnt), 64'(4));
    set_idle();

    // stall counter saturation, then asynchronous reset
    nRST = 0;
    step();
    nRST = 1;
    issue(1, 2, 7, 1, 0, 1, 1, 0);
    step();
    ex_ready = 0;
    issue(7, 0, 3, 0, 1, 1, 0, 0);
    repeat (32'h10000) step();
    chk("sat_ffff", 64'(stall_cnt), 64'(16'hFFFF));
    step();
    chk("sat_hold", 64'(stall_cnt), 64'(16'hFFFF));
    #2;
    nRST = 0;
    #1;
    chk("async_stall", 64'(stall_cnt), 64'(0));
    chk("async_valid", 64'(ex_valid), 64'(0));
    step();
    nRST = 1;
    step();
    chk("post_rst_load", 64'(ex_valid), 64'(1));
    chk("post_rst_stall", 64'(stall_cnt), 64'(0));
    ex_ready = 1;

    // randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 4000; c++) begin
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_alusrc    = 1'($urandom_range(0, 1));
      id_regwrite  = ($urandom_range(0, 3) != 0);
      id_memread   = ($urandom_range(0, 9) < 3);
      id_imm       = $urandom;
      ex_result    = $urandom;
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_rd       = 5'($urandom_range(0, 7));
      mem_wdat     = $urandom;
      ex_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      rf[$urandom_range(1, 31)] = $urandom;
      nRST         = ($urandom_range(0, 199) != 0);
      step();
    end
    nRST = 1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter WORD_W, default 32, sets the datapath word width in bits.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 id_valid  in  1  decode holds a valid instruction.
REQ-005 id_rs, id_rt, id_rd  in  5 each  source 1, source 2, and destination register numbers.
REQ-006 id_uses_rt, id_alusrc, id_regwrite, id_memread  in  1 each  rt is read; operand B takes the immediate; instruction writes a register; instruction is a load.
REQ-007 id_imm  in  WORD_W  extended immediate.
REQ-008 id_ready  out  1  decode instruction is accepted this cycle.
REQ-009 rsel1, rsel2  out  5 each  register-file read selects.
REQ-010 rdat1, rdat2  in  WORD_W each  register-file read data; combinational, and the written value is visible in the same cycle.
REQ-011 ex_result  in  WORD_W  combinational ALU result of the instruction currently held in the output register.
REQ-012 mem_regwrite  in  1; mem_rd  in  5; mem_wdat  in  WORD_W  memory-stage writeback candidate.
REQ-013 ex_ready  in  1  execute stage consumes the output register this cycle.
REQ-014 flush  in  1  squash the output register (branch/jump redirect).
REQ-015 ex_valid, ex_regwrite, ex_memread  out  1 each; ex_rd  out  5.
REQ-016 ex_opA, ex_opB, ex_rtdat  out  WORD_W each  ALU operands and store data.
REQ-017 stall_cnt  out  16  count of cycles stalled on a load-use hazard.

Function
REQ-018 rsel1 SHALL equal id_rs and rsel2 SHALL equal id_rt, combinationally and at all times.
REQ-019 Forwarded source value SHALL be selected per operand with this priority:
  - (a) ex_result if ex_valid, ex_regwrite, !ex_memread, ex_rd==src, and src!=0;
  - (b) else mem_wdat if mem_regwrite, mem_rd==src, and src!=0;
  - (c) else rdat; register 0 SHALL never be forwarded.
REQ-020 hazard SHALL be high when all hold: id_valid, ex_valid, ex_memread, ex_rd!=0, and (ex_rd==id_rs, or (id_uses_rt and ex_rd==id_rt)).
REQ-021 id_ready SHALL equal !hazard && (!ex_valid || ex_ready).
REQ-022 On each rising edge, the first matching rule SHALL apply:
  - flush -> ex_valid<=0;
  - else !ex_valid or ex_ready -> if id_valid and !hazard, load the output register, else ex_valid<=0 (bubble);
  - else hold all output-register fields.
REQ-023 Load SHALL capture ex_opA=fwd(rs), ex_rtdat=fwd(rt), and ex_opB=id_alusrc ? id_imm : fwd(rt), plus id_rd, id_regwrite, id_memread, and set ex_valid=1.
REQ-024 Load-to-use latency SHALL be exactly one bubble cycle, after which the ex_result/mem path supplies the loaded data.
REQ-025 stall_cnt SHALL increment by 1 on each edge where hazard is high and flush is low, and SHALL saturate at 0xFFFF.
REQ-026 flush and hazard together SHALL clear ex_valid; stall_cnt SHALL not increment.
REQ-027 While held (ex_valid && !ex_ready), output fields SHALL stay stable even if mem_* or rdat change.
REQ-028 Output fields SHALL be don't-care when ex_valid=0, but SHALL never produce X after reset.

Reset
REQ-029 On nRST low, all of the following SHALL take effect immediately, independent of CLK: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_rd=0, ex_opA=ex_opB=ex_rtdat=0, and stall_cnt=0.
REQ-030 Reset asserted mid-stall or mid-hold SHALL discard the held instruction; the first edge after release SHALL behave as if ex_valid had been 0.

Verification
REQ-031 Plain load: id_rs=3, rdat1=0x11, id_alusrc=1, id_imm=0x4, ex_ready=1 -> next cycle ex_valid=1, ex_opA=0x11, ex_opB=0x4.
REQ-032 EX forward: held ADD ex_rd=5, ex_result=0xAA; mem_rd=5, mem_wdat=0xBB; id_rs=5 -> loaded ex_opA=0xAA (EX beats MEM).
REQ-033 Load-use: held LW ex_rd=7; id_rt=7, id_uses_rt=1 -> id_ready=0, one bubble (ex_valid=0), stall_cnt=1; next cycle mem_rd=7, mem_wdat=0x55 -> ex_rtdat=0x55.
REQ-034 Register 0: ex_rd=0, ex_regwrite=1, ex_result=0xFF; id_rs=0, rdat1=0 -> ex_opA=0; no hazard for a load with ex_rd=0.
REQ-035 Backpressure/flush: ex_ready=0 for 3 cycles -> outputs unchanged and id_ready=0; then flush=1 -> ex_valid=0 next edge.
REQ-036 Saturation/reset: 0x10000 hazard cycles -> stall_cnt=0xFFFF; async nRST low mid-cycle -> stall_cnt=0 and ex_valid=0 without a clock edge.
